instr_cache: RTL and testbench

- Direct-mapped, read-only instruction cache between the CPU's instruction fetch port (PC in, INSTRUCTION out) and a slow block-wide instruction memory.
- Hits return the addressed 32-bit word in the same cycle.
- Misses stall the CPU via busywait, fetch a 128-bit block from instruction memory, fill the line, then resume.
- Replaces the zero-wait combinational fetch path in the CPU top level.

---
 rtl/icache_pkg.sv | 15 +
 rtl/icache_line_store.sv | 43 ++++
 rtl/instr_cache.sv | 104 ++++++++++
 tb/tb_instr_cache.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and default geometry for the instruction cache.
//   state_e  : miss-handling FSM states (IDLE, MEM_READ, UPDATE)
//   ADDR_W / LINES / WORDS_PER_LINE : default geometry
//   OFF_W / IDX_W / TAG_W / BLK_W   : widths derived from that geometry
package icache_pkg;
  localparam int ADDR_W         = 10;
  localparam int LINES          = 8;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFF_W          = $clog2(WORDS_PER_LINE);
  localparam int IDX_W          = $clog2(LINES);
  localparam int TAG_W          = ADDR_W - IDX_W - OFF_W - 2;
  localparam int BLK_W          = 32 * WORDS_PER_LINE;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_e;
endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for a direct-mapped cache.
//   gclk, grst_n     : clock, async active-low reset (clears valid bits only)
//   wr_en/idx/tag/data : line fill port, sets the line valid
//   rd_idx           : combinational lookup index
//   rd_valid/tag/data  : contents of the indexed line
module icache_line_store #(
  parameter int LINES = 8,
  parameter int TAG_W = 3,
  parameter int BLK_W = 128,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [BLK_W-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [BLK_W-1:0] rd_data
);
  logic [LINES-1:0]            valid_q;
  logic [LINES-1:0][TAG_W-1:0] tag_q;
  logic [LINES-1:0][BLK_W-1:0] data_q;

  // Only the valid vector needs reset; stale tag/data is masked by it.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)    valid_q <= '0;
    else if (wr_en) valid_q[wr_idx] <= 1'b1;
  end

  always_ff @(posedge gclk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];
endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache.
//   CLK, RESET        : clock, async active-low reset
//   read, address     : CPU fetch request (byte address, word aligned)
//   instruction       : fetched word (0 when not a hit)
//   busywait          : CPU stall
//   mem_read, mem_address : block read request {tag,index} to instruction memory
//   mem_readdata, mem_busywait : returned block and memory stall
module instr_cache
  import icache_pkg::*;
#(
  parameter int ADDR_W         = icache_pkg::ADDR_W,
  parameter int LINES          = icache_pkg::LINES,
  parameter int WORDS_PER_LINE = icache_pkg::WORDS_PER_LINE
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              read,
  input  logic [ADDR_W-1:0]                 address,
  output logic [31:0]                       instruction,
  output logic                              busywait,
  output logic                              mem_read,
  output logic [ADDR_W-$clog2(WORDS_PER_LINE)-3:0] mem_address,
  input  logic [32*WORDS_PER_LINE-1:0]      mem_readdata,
  input  logic                              mem_busywait
);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_W - IW - OW - 2;
  localparam int BW = 32 * WORDS_PER_LINE;
  localparam int AW = ADDR_W - OW - 2;

  logic [TW-1:0] addr_tag;
  logic [IW-1:0] addr_idx;
  logic [OW-1:0] addr_off;
  logic          addr_unused;

  assign addr_tag    = address[ADDR_W-1 -: TW];
  assign addr_idx    = address[OW+2 +: IW];
  assign addr_off    = address[OW+1:2];
  assign addr_unused = ^address[1:0];

  state_e state_q, state_d;
  logic [AW-1:0] blk_q;   // block address latched at miss time
  logic          rd_valid;
  logic [TW-1:0] rd_tag;
  logic [BW-1:0] rd_data;
  logic [WORDS_PER_LINE-1:0][31:0] line_words;
  logic          hit, busy, fill;

  icache_line_store #(.LINES(LINES), .TAG_W(TW), .BLK_W(BW)) u_store (
    .gclk     (CLK),
    .grst_n   (RESET),
    .wr_en    (fill),
    .wr_idx   (blk_q[IW-1:0]),
    .wr_tag   (blk_q[AW-1 -: TW]),
    .wr_data  (mem_readdata),
    .rd_idx   (addr_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  assign hit         = read && rd_valid && (rd_tag == addr_tag);
  assign line_words  = rd_data;
  assign instruction = hit ? line_words[addr_off] : 32'h0;
  assign fill        = (state_q == MEM_READ) && !mem_busywait;
  assign mem_address = blk_q;
  // Reset forces the stall low even though read may still be high.
  assign busywait    = busy && RESET;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && read && !hit) blk_q <= {addr_tag, addr_idx};
    end
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    mem_read = 1'b0;
    case (state_q)
      IDLE: begin
        if (read && !hit) begin
          busy    = 1'b1;
          state_d = MEM_READ;
        end
      end
      MEM_READ: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        if (!mem_busywait) state_d = UPDATE;
      end
      UPDATE: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_instr_cache.sv
module tb_instr_cache;
  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         read = 1'b0;
  logic [9:0]   address = '0;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata = '0;
  logic         mem_busywait = 1'b1;

  instr_cache dut (
    .CLK(CLK), .RESET(RESET), .read(read), .address(address),
    .instruction(instruction), .busywait(busywait),
    .mem_read(mem_read), .mem_address(mem_address),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    bit          hit;
    logic [5:0]  blk;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;
  int   mem_lat = 0;
  bit   mon_en = 0;
  bit   mv[8];
  int   mt[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory: word content equals its word address; stalls mem_lat cycles.
  int rcnt = 0;
  always @(posedge CLK) begin
    #1;
    if (mem_read) begin
      if (rcnt < mem_lat) begin
        mem_busywait = 1'b1;
        rcnt++;
      end else begin
        mem_busywait = 1'b0;
        for (int i = 0; i < 4; i++)
          mem_readdata[i*32 +: 32] = (32'(mem_address) << 2) | 32'(i);
      end
    end else begin
      rcnt = 0;
      mem_busywait = 1'b1;
    end
  end

  // Monitor: one accepted request per negedge with read && !busywait.
  int busy_cnt = 0;
  bit mr_seen = 0;
  always @(negedge CLK) begin
    exp_t e;
    if (!RESET || !mon_en) begin
      busy_cnt = 0;
      mr_seen  = 0;
    end else begin
      if (mem_read && !mr_seen) begin
        mr_seen = 1;
        if (sb.size() == 0) check("mem_read_unexpected", 32'd1, 32'd0);
        else begin
          check("mem_read_on_hit", 32'(sb[0].hit), 32'd0);
          check("mem_address", 32'(mem_address), 32'(sb[0].blk));
        end
      end
      if (!mem_read) mr_seen = 0;
      if (read && busywait) busy_cnt++;
      else if (read) begin
        if (sb.size() == 0) check("accept_unexpected", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("instruction", instruction, e.instr);
          check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
        end
        busy_cnt = 0;
      end
    end
  end

  // Reference: per-index valid/tag; a miss costs lat+3 stall cycles total.
  task automatic fetch(input logic [9:0] a, input int lat);
    exp_t e;
    int idx, tg;
    bit done;
    idx = int'(a[6:4]);
    tg  = int'(a[9:7]);
    e.hit   = mv[idx] && (mt[idx] == tg);
    e.instr = 32'(a >> 2);
    e.blk   = a[9:4];
    e.lat   = e.hit ? 0 : lat + 3;
    if (!e.hit) begin
      mv[idx] = 1;
      mt[idx] = tg;
    end
    mem_lat = lat;
    sb.push_back(e);
    read    = 1'b1;
    address = a;
    done    = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge CLK);
      if (!busywait) begin
        done = 1;
        break;
      end
    end
    if (!done) check("fetch_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 0;
      mt[i] = 0;
    end
  endtask

  initial begin
    clear_model();
    // Reset with a pending request
    RESET = 1'b0; read = 1'b1; address = 10'h000;
    repeat (3) @(negedge CLK);
    check("rst_busywait", 32'(busywait), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1; mon_en = 1;

    fetch(10'h000, 4);                 // cold miss, 7 stall cycles
    fetch(10'h004, 0);                 // same-line hits
    fetch(10'h008, 0);
    fetch(10'h00C, 0);
    fetch(10'h080, 2);                 // conflict on index 0
    fetch(10'h000, 1);                 // evicted, misses again

    // Idle with an invalid line
    read = 1'b0; address = 10'h3F0;
    repeat (3) begin
      @(negedge CLK);
      check("idle_busywait", 32'(busywait), 32'd0);
      check("idle_mem_read", 32'(mem_read), 32'd0);
    end
    @(posedge CLK); #1;
    fetch(10'h3F0, 0);

    // Reset during the second MEM_READ cycle
    mon_en = 0;
    mem_lat = 6;
    read = 1'b1; address = 10'h100;
    @(posedge CLK);
    @(posedge CLK); #2;
    check("midfetch_mem_read_before", 32'(mem_read), 32'd1);
    RESET = 1'b0; #1;
    check("midfetch_mem_read", 32'(mem_read), 32'd0);
    check("midfetch_busywait", 32'(busywait), 32'd0);
    clear_model();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1; mon_en = 1;
    fetch(10'h000, 1);                 // all lines invalid again
    fetch(10'h100, 0);

    // Randomized traffic over a small footprint to mix hits and misses
    for (int n = 0; n < 200; n++)
      fetch(10'($urandom_range(0, 383)), int'($urandom_range(0, 3)));

    read = 1'b0;
    repeat (3) @(negedge CLK);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
